// File: rtl/tensor_reader.sv
// Streams one DIM x DIM entry of the tensor memory onto a valid/ready output.
// Define TENSOR_READER_TRANSPOSE_EN to traverse in column-major order.
module tensor_reader #(
  parameter int ENTRY_NUM = 1,
  parameter int DIM       = 1,
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          entry,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 mem_write,
  output logic [2:0][15:0]     mem_index,
  input  logic [DATA_SIZE-1:0] mem_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [15:0]          out_row,
  output logic [15:0]          out_col,
  output logic                 out_last
);

  localparam logic [15:0] LAST_IDX = 16'(DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t                 state_r, next_state_s;
  logic [15:0]            entry_r, row_r, col_r;
  logic [15:0]            row_nxt_s, col_nxt_s;
  logic                   entry_bad_s, last_elem_s, load_s, finish_s, accept_s;
  logic                   busy_r, done_r, err_r;
  logic                   out_valid_r, out_last_r;
  logic [DATA_SIZE-1:0]   out_data_r;
  logic [15:0]            out_row_r, out_col_r;

  assign entry_bad_s = ({16'd0, entry} >= $unsigned(32'(ENTRY_NUM)));
  assign last_elem_s = (row_r == LAST_IDX) && (col_r == LAST_IDX);

  // Next state and per-cycle strobes.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    finish_s     = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (entry_bad_s) begin
            next_state_s = ST_ERR;
          end else begin
            accept_s     = 1'b1;
            next_state_s = ST_STREAM;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        load_s = !out_valid_r || out_ready;
        if (load_s && last_elem_s) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        finish_s = out_valid_r && out_ready && out_last_r;
        if (finish_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_ERR: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Coordinate advance; the inner counter wraps into the outer one.
  always_comb begin
    row_nxt_s = row_r;
    col_nxt_s = col_r;
`ifdef TENSOR_READER_TRANSPOSE_EN
    if (row_r == LAST_IDX) begin
      row_nxt_s = 16'd0;
      col_nxt_s = col_r + 16'd1;
    end else begin
      row_nxt_s = row_r + 16'd1;
    end
`else
    if (col_r == LAST_IDX) begin
      col_nxt_s = 16'd0;
      row_nxt_s = row_r + 16'd1;
    end else begin
      col_nxt_s = col_r + 16'd1;
    end
`endif
  end

  // Memory index is only driven while an entry is being walked.
  always_comb begin
    mem_index = '0;
    if (state_r == ST_STREAM || state_r == ST_DRAIN) begin
      mem_index = {entry_r, row_r, col_r};
    end else begin
      mem_index = '0;
    end
  end

  // State, counters, status flags and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      entry_r     <= 16'd0;
      row_r       <= 16'd0;
      col_r       <= 16'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
      out_row_r   <= 16'd0;
      out_col_r   <= 16'd0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_STREAM) || (next_state_s == ST_DRAIN);
      done_r  <= (next_state_s == ST_ERR) || finish_s;
      err_r   <= (next_state_s == ST_ERR);
      if (accept_s) begin
        entry_r <= entry;
        row_r   <= 16'd0;
        col_r   <= 16'd0;
      end else if (load_s && !last_elem_s) begin
        row_r <= row_nxt_s;
        col_r <= col_nxt_s;
      end
      // Hold the beat while the consumer stalls; refill on acceptance.
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= mem_data;
        out_row_r   <= row_r;
        out_col_r   <= col_r;
        out_last_r  <= last_elem_s;
      end else if (finish_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign mem_write = 1'b0;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_row   = out_row_r;
  assign out_col   = out_col_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_tensor_reader.sv
// Scoreboard bench for tensor_reader with ENTRY_NUM=2, DIM=3.
module tb_tensor_reader;

  localparam int EN = 2;
  localparam int D  = 3;
  localparam int W  = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [15:0]     entry = 16'd0;
  logic            busy, done, err, mem_write;
  logic [2:0][15:0] mem_index;
  logic [W-1:0]    mem_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    out_data;
  logic [15:0]     out_row, out_col;
  logic            out_last;

  typedef struct packed {
    logic [W-1:0] data;
    logic [15:0]  row;
    logic [15:0]  col;
    logic         last;
  } beat_t;

  beat_t        sb_q[$];
  logic [W-1:0] mem [0:EN-1][0:D-1][0:D-1];
  int           checks = 0;
  int           errors = 0;
  int           beats = 0;
  int           done_cnt = 0;
  int           cyc;

  tensor_reader #(.ENTRY_NUM(EN), .DIM(D), .DATA_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .entry(entry),
    .busy(busy), .done(done), .err(err), .mem_write(mem_write),
    .mem_index(mem_index), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  always #5 clk = ~clk;

  assign mem_data = (int'(mem_index[2]) < EN && int'(mem_index[1]) < D && int'(mem_index[0]) < D)
                    ? mem[mem_index[2]][mem_index[1]][mem_index[0]] : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_expected(input int ent);
    beat_t b;
    for (int o = 0; o < D; o++) begin
      for (int i = 0; i < D; i++) begin
`ifdef TENSOR_READER_TRANSPOSE_EN
        b.row = 16'(i);
        b.col = 16'(o);
`else
        b.row = 16'(o);
        b.col = 16'(i);
`endif
        b.data = mem[ent][b.row][b.col];
        b.last = (int'(b.row) == D - 1) && (int'(b.col) == D - 1);
        sb_q.push_back(b);
      end
    end
  endtask

  task automatic pulse_start(input int ent);
    @(posedge clk); #1;
    start = 1'b1;
    entry = 16'(ent);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts negedges after the start edge until done, optionally toggling ready.
  task automatic wait_done(input int max_cyc, input bit toggle, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
      @(posedge clk); #1;
      if (toggle) out_ready = !out_ready;
    end
    if (n < 0) check("done_timeout", 64'(0), 64'(1));
  endtask

  // Output monitor: scoreboard pop on handshake plus stall stability.
  initial begin : monitor
    beat_t exp_b;
    logic  hold;
    logic [W-1:0] h_data;
    logic [15:0]  h_row, h_col;
    hold = 1'b0;
    h_data = '0; h_row = '0; h_col = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold && out_valid) begin
          check("stall_data", out_data, h_data);
          check("stall_row", 64'(out_row), 64'(h_row));
          check("stall_col", 64'(out_col), 64'(h_col));
        end
        if (out_valid && out_ready) begin
          check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
          if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front();
            check("beat_data", out_data, exp_b.data);
            check("beat_row", 64'(out_row), 64'(exp_b.row));
            check("beat_col", 64'(out_col), 64'(exp_b.col));
            check("beat_last", 64'(out_last), 64'(exp_b.last));
          end
          beats++;
          hold = 1'b0;
        end else if (out_valid) begin
          hold   = 1'b1;
          h_data = out_data;
          h_row  = out_row;
          h_col  = out_col;
        end else begin
          hold = 1'b0;
        end
        if (done) done_cnt++;
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_mem_write"}, 64'(mem_write), 64'(0));
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_last"}, 64'(out_last), 64'(0));
    check({tag, "_index"}, 64'(mem_index), 64'(0));
    check({tag, "_data"}, out_data, 64'(0));
    check({tag, "_row"}, 64'(out_row), 64'(0));
    check({tag, "_col"}, 64'(out_col), 64'(0));
  endtask

  initial begin
    for (int e = 0; e < EN; e++)
      for (int r = 0; r < D; r++)
        for (int c = 0; c < D; c++)
          mem[e][r][c] = (e == 1) ? 64'(r * 3 + c) : 64'(32'h1000 + r * 3 + c);

    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full stream, ready held high.
    push_expected(1);
    pulse_start(1);
    check("start_busy", 64'(busy), 64'(1));
    check("start_valid", 64'(out_valid), 64'(0));
    wait_done(40, 1'b0, cyc);
    check("latency", 64'(cyc), 64'(D * D + 2));
    check("done_err", 64'(err), 64'(0));
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    // Ready toggling every cycle.
    push_expected(1);
    pulse_start(1);
    wait_done(100, 1'b1, cyc);
    check("toggle_err", 64'(err), 64'(0));
    check("toggle_drained", 64'(sb_q.size()), 64'(0));
    out_ready = 1'b1;

    // Out-of-range entry.
    beats = 0;
    pulse_start(2);
    @(negedge clk);
    check("bad_done", 64'(done), 64'(1));
    check("bad_err", 64'(err), 64'(1));
    check("bad_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("bad_done_clear", 64'(done), 64'(0));
    check("bad_err_clear", 64'(err), 64'(0));
    repeat (3) @(negedge clk);
    check("bad_no_beats", 64'(beats), 64'(0));

    // Start re-pulsed mid-stream is ignored.
    done_cnt = 0;
    push_expected(1);
    pulse_start(1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    entry = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, 1'b0, cyc);
    repeat (15) @(negedge clk);
    check("restart_done_cnt", 64'(done_cnt), 64'(1));
    check("restart_drained", 64'(sb_q.size()), 64'(0));

    // Reset after beat 5, then a clean stream.
    beats = 0;
    push_expected(1);
    pulse_start(1);
    for (int i = 0; i < 30 && beats < 5; i++) @(negedge clk);
    check("pre_reset_beats", 64'(beats), 64'(5));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_expected(1);
    pulse_start(1);
    wait_done(40, 1'b0, cyc);
    check("post_reset_latency", 64'(cyc), 64'(D * D + 2));
    check("post_reset_drained", 64'(sb_q.size()), 64'(0));

    // Entry 0 checks the entry index reaches the memory.
    push_expected(0);
    pulse_start(0);
    wait_done(40, 1'b0, cyc);
    check("entry0_drained", 64'(sb_q.size()), 64'(0));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tensor_reader.md
# tensor_reader

Sequential read-side initiator for the single-port tensor memory. On `start` it walks every element of one entry (`DIM`×`DIM`, row-major), drives the memory's 3-level index, and captures the combinational read data into an output register. That register feeds a valid/ready stream consumed by the DNN datapath (e.g. a MAC/activation stage). It is the reader counterpart to the write path that fills the memory.

## Interface
- `ENTRY_NUM`, 1, number of entries in the attached memory
- `DIM`, 1, rows = columns per entry; 1..65535
- `DATA_SIZE`, 64, element width (IEEE-754 double bits)

- `clk`  in  1  sole clock; all state updates on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin streaming entry `entry`; accepted only in IDLE
- `entry`  in  16  entry to read; sampled with accepted `start`
- `busy`  out  1  high in STREAM and DRAIN
- `done`  out  1  one-cycle pulse on completion or error
- `err`  out  1  valid with `done`; 1 = `entry` ≥ `ENTRY_NUM`
- `mem_write`  out  1  memory write enable; constant 0
- `mem_index`  out  3×16  memory index; [2]=entry, [1]=row, [0]=col
- `mem_data`  in  DATA_SIZE  combinational read data for `mem_index`
- `out_valid`  out  1  stream data valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  DATA_SIZE  element
- `out_row`, `out_col`  out  16 each  coordinates of `out_data`
- `out_last`  out  1  marks final element of the entry

## Operation
- FSM: IDLE, STREAM, DRAIN, ERR.
- IDLE: `mem_index` = {0,0,0}. On `start`: if `entry` ≥ `ENTRY_NUM` → ERR; else latch entry, clear row/col counters → STREAM.
- ERR: one cycle; asserts `done`=1, `err`=1 → IDLE. No beats emitted.
- STREAM: `mem_index` = {entry_q, row, col}. Output register loads when `!out_valid || out_ready`: `out_data`←`mem_data`, `out_row`/`out_col`←row/col, `out_last`←(row==DIM-1 && col==DIM-1), `out_valid`←1. On load, col increments; at col==DIM-1, col←0 and row increments. Load of the last element → DRAIN.
- DRAIN: counters frozen; on `out_valid && out_ready && out_last` → `out_valid`←0, `done` pulse (`err`=0) → IDLE.
- Output register holds data and coordinates stable while `out_valid && !out_ready`.
- `start` while not IDLE: ignored, no side effects.
- DIM=1: single beat with `out_last`=1.

## Timing
- Reset values: `busy`, `done`, `err`, `mem_write`, `out_valid`, `out_last` = 0; `mem_index`, `out_data`, `out_row`, `out_col` = 0; state IDLE.
- `start` at edge N → STREAM in N+1; first `out_valid` visible after edge N+2.
- `out_ready` held high: one beat per cycle, DIM² consecutive beats; `done` high in the cycle after the `out_last` handshake edge.
- Total latency, ready high: DIM²+2 cycles start-to-done.
- Error: `done`/`err` high in the cycle after `start` edge.
- Back-pressure: zero bubbles added; beat k+1 issues in the same cycle beat k is accepted.
- `rst_n` low mid-stream: immediate return to reset values; no `done`; partial stream discarded.

## Configuration
- `TENSOR_READER_TRANSPOSE_EN` defined: traversal is column-major — row increments first, col increments at row wrap; `out_row`/`out_col` still report true coordinates; `out_last` unchanged (row==col==DIM-1).
- Undefined: row-major only as above.

## Test plan
- ENTRY_NUM=2, DIM=3, mem[1][r][c]=r*3+c, `entry`=1, ready high → 9 beats 0..8 in consecutive cycles, `out_last` only on beat 8, `done` one cycle later, `err`=0.
- Same, `out_ready` toggling 1/0 each cycle → same 9 values in order, data/coords stable during stalls, no drops or duplicates.
- `entry`=2 (≥ENTRY_NUM) → `done`=`err`=1 one cycle after start, `out_valid` never asserted, `busy` stays 0.
- `start` pulsed again at beat 4 → ignored; stream completes unchanged with a single `done`.
- `rst_n` low after beat 5 → all outputs zero immediately; new `start` afterwards streams full 9 beats from (0,0).
- `TENSOR_READER_TRANSPOSE_EN`, DIM=3 → values 0,3,6,1,4,7,2,5,8, `out_last` on value 8.
